result_stream_packer: RTL and testbench
=======================================

// Module: result_stream_packer
// PURPOSE
//  Output-side counterpart of the line-buffer input path.
//  - Accepts convolution result bytes, one per handshake.
//  - Packs them little-endian into 32-bit words.
//  - Emits the words on an AXI4-Stream master toward the DDR writer, with TKEEP/TLAST framing.
//  - One frame = FRAME_LEN result bytes (one output feature map); a frame's last word may be partial.
//  - A small output FIFO absorbs TREADY stalls; input is backpressured when that FIFO is full.
// PARAMETERS
//  FRAME_LEN   1681  result bytes per frame (41x41 map); legal range 1..65535
//  FIFO_DEPTH  4     output word FIFO entries; power of two, >=2
// PORTS
//  CLK            in   1   sole clock, rising edge
//  RESETN         in   1   asynchronous assert, active-low reset
//  in_valid       in   1   in_data holds a result byte
//  in_data        in   8   result byte
//  in_ready       out  1   byte accepted on edge where in_valid & in_ready
//  M_AXIS_TDATA   out  32  packed word, byte k in bits [8k+7:8k]
//  M_AXIS_TKEEP   out  4   valid-lane mask
//  M_AXIS_TLAST   out  1   word holds final byte of frame
//  M_AXIS_TVALID  out  1   FIFO head valid
//  M_AXIS_TREADY  in   1   downstream accepts
//  frame_count    out  16  frames completed on M_AXIS (wraps 0xFFFF->0)
// BEHAVIOUR
//  Reset (RESETN=0, async):
//   - FIFO emptied; lane=0, byte_cnt=0, frame_count=0, state=IDLE.
//   - TVALID=0, TDATA=0, TKEEP=0, TLAST=0, in_ready=0.
//   - First edge after release: in_ready=1.
//  Reset mid-frame discards the partial word and all queued words; the next accepted byte is byte 0 of a new frame.
//  Input side:
//   - in_ready = !fifo_full, registered; no combinational path from TREADY.
//   - Each accepted byte goes to pack[lane] and advances lane (0..3) and byte_cnt (0..FRAME_LEN-1).
//   - A word is pushed on the accepting edge when lane==3 or byte_cnt==FRAME_LEN-1.
//   - Push contents: TKEEP = lanes written; unwritten lanes zero; TLAST=1 iff byte_cnt==FRAME_LEN-1.
//   - Last byte of a frame: lane and byte_cnt return to 0, so the next frame always starts in lane 0.
//  FSM (input side):
//   - IDLE: byte_cnt==0, lane==0. First accepted byte -> PACK.
//   - PACK: collecting bytes. Accepting byte FRAME_LEN-1 -> IDLE.
//   - FRAME_LEN==1: every byte is pushed alone with TKEEP=0001, TLAST=1; state stays IDLE.
//  Output side:
//   - TVALID = fifo_not_empty. TDATA/TKEEP/TLAST come from the FIFO head.
//   - The head is held stable while TVALID & !TREADY.
//   - Pop on TVALID & TREADY.
//   - frame_count += 1 on each pop where TLAST=1.
//  Latency: a pushed word is visible on TVALID the cycle after its last byte's accepting edge (FIFO empty case).
//  Simultaneous push and pop:
//   - Occupancy unchanged; legal at any occupancy.
//   - When full, in_ready is already 0, so no push occurs that cycle; in_ready rises the cycle after the pop.
//  Throughput: 1 byte/cycle in; 1 word/cycle out capacity; no bubbles with TREADY=1.
//  Arithmetic: byte_cnt is 16 bits and compared against FRAME_LEN-1; lane is 2 bits and wraps 3->0.
// TESTING
//  T1 (FRAME_LEN=8, TREADY=1)
//     Stimulus: bytes 01..08.
//     Required: 0x04030201 KEEP=F LAST=0, then 0x08070605 KEEP=F LAST=1; frame_count=1.
//  T2 (default FRAME_LEN, TREADY=1)
//     Stimulus: bytes n%256 for n=0..1680.
//     Required: 421 words; last word = 0x00000090, KEEP=1, LAST=1; word 0 = 0x03020100.
//  T3 (TREADY=0, in_valid=1 held)
//     Required: exactly 16 bytes accepted; in_ready=0 from then on.
//     Then raise TREADY: the 4 words drain in order, and byte 17 is accepted the cycle after the first pop.
//  T4 (FRAME_LEN=6, back-to-back frames 01..06, 07..0C)
//     Required: 0x04030201/F/0, 0x00000605/3/1, 0x0A090807/F/0, 0x00000C0B/3/1.
//  T5 (reset mid-frame)
//     Stimulus: pull RESETN low after 5 bytes.
//     Required: TVALID=0 immediately (async), no residual words; next frame word 0 begins in lane 0.
//  T6 (random TREADY/in_valid, 1000 frames, FRAME_LEN=7)
//     Required: scoreboard shows no drop/duplication, TDATA stable under stall, frame_count=1000.

Source files
------------

// File: rtl/result_stream_packer.sv
// Packs result bytes little-endian into 32-bit words and
// streams them out over AXI4-Stream with TKEEP/TLAST framing.
module result_stream_packer #(
  parameter int unsigned FRAME_LEN  = 1681,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] M_AXIS_TDATA,
  output logic [3:0]  M_AXIS_TKEEP,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [15:0] frame_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [AW:0] FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  typedef enum logic {
    IDLE,
    PACK
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] pack_q, pack_d;
  logic        rdy_q, rdy_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   occ_q, occ_d;
  word_t       mem_q [FIFO_DEPTH];

  logic  acc;
  logic  is_last;
  logic  push;
  logic  pop;
  logic  head_vld;
  word_t head;
  word_t pw;

  assign acc      = in_valid & rdy_q;
  assign is_last  = (cnt_q == LAST_IDX);
  assign push     = acc & ((lane_q == 2'd3) | is_last);
  assign head_vld = (occ_q != '0);
  assign head     = mem_q[rd_q];
  assign pop      = head_vld & M_AXIS_TREADY;

  // Word being pushed: held lanes plus the incoming byte, upper lanes zero.
  always_comb begin
    pw = '0;
    pw.last = is_last;
    unique case (lane_q)
      2'd0: begin
        pw.data = {24'h0, in_data};
        pw.keep = 4'b0001;
      end
      2'd1: begin
        pw.data = {16'h0, in_data, pack_q[7:0]};
        pw.keep = 4'b0011;
      end
      2'd2: begin
        pw.data = {8'h0, in_data, pack_q[15:0]};
        pw.keep = 4'b0111;
      end
      default: begin
        pw.data = {in_data, pack_q};
        pw.keep = 4'b1111;
      end
    endcase
  end

  // Input-side FSM, lane/byte counters and pack register next state.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    if (acc) begin
      if (is_last) begin
        lane_d = 2'd0;
        cnt_d  = 16'd0;
      end else begin
        lane_d = lane_q + 2'd1;
        cnt_d  = cnt_q + 16'd1;
      end
      if (push) begin
        pack_d = '0;
      end else begin
        unique case (lane_q)
          2'd0:    pack_d[7:0]   = in_data;
          2'd1:    pack_d[15:8]  = in_data;
          default: pack_d[23:16] = in_data;
        endcase
      end
    end
    unique case (state_q)
      IDLE: if (acc && !is_last) state_d = PACK;
      default: if (acc && is_last) state_d = IDLE;
    endcase
  end

  // FIFO pointers, occupancy, registered ready and frame counter.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    occ_d  = occ_q;
    fcnt_d = fcnt_q;
    if (push) wr_d = wr_q + PTR_ONE;
    if (pop)  rd_d = rd_q + PTR_ONE;
    if (push && !pop) begin
      occ_d = occ_q + OCC_ONE;
    end else if (!push && pop) begin
      occ_d = occ_q - OCC_ONE;
    end
    if (pop && head.last) fcnt_d = fcnt_q + 16'd1;
    rdy_d = (occ_d != FULL);
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
      cnt_q   <= 16'd0;
      pack_q  <= '0;
      rdy_q   <= 1'b0;
      fcnt_q  <= 16'd0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      rdy_q   <= rdy_d;
      fcnt_q  <= fcnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
    end
  end

  // Word storage; written only on push.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_q] <= pw;
    end
  end

  assign in_ready      = rdy_q;
  assign M_AXIS_TVALID = head_vld;
  assign M_AXIS_TDATA  = head_vld ? head.data : 32'h0;
  assign M_AXIS_TKEEP  = head_vld ? head.keep : 4'h0;
  assign M_AXIS_TLAST  = head_vld ? head.last : 1'b0;
  assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_result_stream_packer.sv
// Directed bench for result_stream_packer over several
// frame lengths, with a word scoreboard and stall checks.
module tb_result_stream_packer;

  localparam int unsigned FLS [5] = '{8, 6, 7, 1681, 1};
  localparam int D8 = 0;
  localparam int D6 = 1;
  localparam int D7 = 2;
  localparam int DB = 3;
  localparam int D1 = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } wd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h0;
  logic       tready = 1'b0;
  int         sel = 0;

  logic        rdy [5];
  logic [31:0] td  [5];
  logic [3:0]  tk  [5];
  logic        tl  [5];
  logic        tv  [5];
  logic [15:0] fc  [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    result_stream_packer #(
      .FRAME_LEN (FLS[g]),
      .FIFO_DEPTH(4)
    ) u_dut (
      .CLK          (clk),
      .RESETN       (rst_n),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (rdy[g]),
      .M_AXIS_TDATA (td[g]),
      .M_AXIS_TKEEP (tk[g]),
      .M_AXIS_TLAST (tl[g]),
      .M_AXIS_TVALID(tv[g]),
      .M_AXIS_TREADY(tready),
      .frame_count  (fc[g])
    );
  end

  logic        m_rdy, m_tv, m_tl;
  logic [31:0] m_td;
  logic [3:0]  m_tk;
  logic [15:0] m_fc;

  assign m_rdy = rdy[sel];
  assign m_td  = td[sel];
  assign m_tk  = tk[sel];
  assign m_tl  = tl[sel];
  assign m_tv  = tv[sel];
  assign m_fc  = fc[sel];

  int  nvec = 0;
  int  nerr = 0;
  int  cyc = 0;
  int  first_pop = -1;
  int  first_vld = -1;
  logic prev_stall = 1'b0;
  wd_t  prev_w;
  wd_t  rxq [$];
  int   acc_cyc [$];
  wd_t  expq [$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Sample handshakes on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stable", {m_td, m_tk, m_tl}, prev_w);
      end
      if (m_tv && first_vld < 0) first_vld = cyc;
      if (m_tv && tready) begin
        rxq.push_back(wd_t'{m_td, m_tk, m_tl});
        if (first_pop < 0) first_pop = cyc;
      end
      if (in_valid && m_rdy) acc_cyc.push_back(cyc);
      prev_stall = m_tv && !tready;
      prev_w = wd_t'{m_td, m_tk, m_tl};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int s);
    sel = s;
    in_valid = 1'b0;
    in_data = 8'h0;
    tready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_tvalid", m_tv, 1'b0);
    chk("rst_tdata", m_td, 32'h0);
    chk("rst_tkeep", m_tk, 4'h0);
    chk("rst_tlast", m_tl, 1'b0);
    chk("rst_ready", m_rdy, 1'b0);
    chk("rst_fcnt", m_fc, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    rxq.delete();
    acc_cyc.delete();
    first_pop = -1;
    first_vld = -1;
    tick();
    chk("ready_after_rst", m_rdy, 1'b1);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit rnd);
    int  t = 0;
    bit  ok = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    while (!ok && t < 1000) begin
      @(negedge clk);
      ok = m_rdy;
      tick();
      if (rnd) tready = ($urandom_range(0, 3) != 0);
      t++;
    end
    if (!ok) chk("push_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    tready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic chk_word(input string tag, input int i, input wd_t w);
    wd_t got;
    got = (i < rxq.size()) ? rxq[i] : wd_t'('1);
    chk(tag, got, w);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;

    // T1: two full words, framing and push-to-TVALID latency.
    do_reset(D8);
    tready = 1'b1;
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b0);
    drain(5);
    chk("t1_words", rxq.size(), 2);
    chk_word("t1_w0", 0, wd_t'{32'h04030201, 4'hF, 1'b0});
    chk_word("t1_w1", 1, wd_t'{32'h08070605, 4'hF, 1'b1});
    chk("t1_fcnt", m_fc, 16'd1);
    chk("t1_lat", first_vld, acc_cyc[3] + 1);

    // T2: default frame length with a partial last word.
    do_reset(DB);
    tready = 1'b1;
    for (int n = 0; n < 1681; n++) push_byte(8'(n), 1'b0);
    drain(6);
    chk("t2_words", rxq.size(), 421);
    chk_word("t2_w0", 0, wd_t'{32'h03020100, 4'hF, 1'b0});
    chk_word("t2_w419", 419, wd_t'{32'h8F8E8D8C, 4'hF, 1'b0});
    chk_word("t2_wlast", 420, wd_t'{32'h00000090, 4'h1, 1'b1});
    chk("t2_fcnt", m_fc, 16'd1);
    chk("t2_nobubble", acc_cyc[1680] - acc_cyc[0], 1680);

    // T3: backpressure fills the FIFO, then drains in order.
    do_reset(DB);
    tready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_data = 8'(acc_cyc.size() + 1);
      tick();
    end
    chk("t3_acc16", acc_cyc.size(), 16);
    chk("t3_ready0", m_rdy, 1'b0);
    tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(acc_cyc.size() + 1);
      tick();
    end
    in_valid = 1'b0;
    drain(4);
    chk_word("t3_w0", 0, wd_t'{32'h04030201, 4'hF, 1'b0});
    chk_word("t3_w1", 1, wd_t'{32'h08070605, 4'hF, 1'b0});
    chk_word("t3_w2", 2, wd_t'{32'h0C0B0A09, 4'hF, 1'b0});
    chk_word("t3_w3", 3, wd_t'{32'h100F0E0D, 4'hF, 1'b0});
    t = (acc_cyc.size() > 16) ? acc_cyc[16] : -1;
    chk("t3_b17", t, first_pop + 1);

    // T4: back-to-back short frames.
    do_reset(D6);
    tready = 1'b1;
    for (int i = 1; i <= 12; i++) push_byte(8'(i), 1'b0);
    drain(5);
    chk("t4_words", rxq.size(), 4);
    chk_word("t4_w0", 0, wd_t'{32'h04030201, 4'hF, 1'b0});
    chk_word("t4_w1", 1, wd_t'{32'h00000605, 4'h3, 1'b1});
    chk_word("t4_w2", 2, wd_t'{32'h0A090807, 4'hF, 1'b0});
    chk_word("t4_w3", 3, wd_t'{32'h00000C0B, 4'h3, 1'b1});
    chk("t4_fcnt", m_fc, 16'd2);

    // T5: reset mid-frame with a word queued.
    do_reset(D8);
    tready = 1'b0;
    for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b0);
    tick();
    chk("t5_pre_tvalid", m_tv, 1'b1);
    do_reset(D8);
    tready = 1'b1;
    for (int i = 17; i <= 24; i++) push_byte(8'(i), 1'b0);
    drain(5);
    chk("t5_words", rxq.size(), 2);
    chk_word("t5_w0", 0, wd_t'{32'h14131211, 4'hF, 1'b0});
    chk_word("t5_w1", 1, wd_t'{32'h18171615, 4'hF, 1'b1});
    chk("t5_fcnt", m_fc, 16'd1);

    // T7: one-byte frames.
    do_reset(D1);
    tready = 1'b1;
    push_byte(8'hA5, 1'b0);
    push_byte(8'h5A, 1'b0);
    push_byte(8'h3C, 1'b0);
    drain(4);
    chk("t7_words", rxq.size(), 3);
    chk_word("t7_w0", 0, wd_t'{32'h000000A5, 4'h1, 1'b1});
    chk_word("t7_w2", 2, wd_t'{32'h0000003C, 4'h1, 1'b1});
    chk("t7_fcnt", m_fc, 16'd3);

    // T6: random stalls on both sides, 1000 frames of 7 bytes.
    do_reset(D7);
    expq.delete();
    for (int f = 0; f < 1000; f++) begin
      logic [7:0] b [7];
      for (int j = 0; j < 7; j++) b[j] = 8'((f * 7 + j) * 7 + 3);
      expq.push_back(wd_t'{{b[3], b[2], b[1], b[0]}, 4'hF, 1'b0});
      expq.push_back(wd_t'{{8'h0, b[6], b[5], b[4]}, 4'h7, 1'b1});
    end
    for (int i = 0; i < 7000; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        tready = ($urandom_range(0, 3) != 0);
        tick();
      end
      push_byte(8'(i * 7 + 3), 1'b1);
    end
    drain(10);
    chk("t6_words", rxq.size(), 2000);
    for (int i = 0; i < 2000; i++) begin
      chk_word("t6_word", i, expq[i]);
    end
    chk("t6_fcnt", m_fc, 16'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
